// File: rtl/basilisk_register_scoreboard_pkg.sv
// Shared types and constants for the basilisk floating-point/vector register scoreboard.
package basilisk_register_scoreboard_pkg;

   localparam int BASILISK_SCOREBOARD_COUNTER_WIDTH = 2;
   localparam int BASILISK_NUM_REGS = 32;

   typedef logic [4:0] basilisk_reg_addr_t;
   typedef logic [BASILISK_SCOREBOARD_COUNTER_WIDTH-1:0] basilisk_scoreboard_count_t;

endpackage

// File: rtl/basilisk_scoreboard_counter.sv
// Outstanding-write counter for one register: one reservation in, up to N releases out per cycle.
module basilisk_scoreboard_counter #(
   parameter int WIDTH = 2,
   parameter int DEC_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic [DEC_W-1:0] dec,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             zero,
   output logic             full,
   output logic             underflow
);

   localparam int SUM_W = WIDTH + 2;
   localparam logic [WIDTH-1:0] MAX = '1;

   logic [WIDTH-1:0]        count_q;
   logic signed [SUM_W-1:0] next_sum;

   always_comb begin
      next_sum = $signed(SUM_W'(count_q)) + $signed(SUM_W'(inc)) - $signed(SUM_W'(dec));
   end

   // A flush wins over the release, so it never reports an underflow.
   assign underflow = !clear && next_sum[SUM_W-1];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (underflow) begin
         count_q <= '0;
      end else if (next_sum > $signed(SUM_W'(MAX))) begin
         count_q <= MAX;
      end else begin
         count_q <= next_sum[WIDTH-1:0];
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);
   assign full  = (count_q == MAX);

endmodule

// File: rtl/basilisk_register_scoreboard.sv
// Pending-write scoreboard: decode reserves a register at issue, writeback ports release it.
module basilisk_register_scoreboard
   import basilisk_register_scoreboard_pkg::*;
#(
   parameter int NUM_REGS        = BASILISK_NUM_REGS,
   parameter int COUNTER_WIDTH   = BASILISK_SCOREBOARD_COUNTER_WIDTH,
   parameter int WRITEBACK_PORTS = 2,
   localparam int ADDR_W         = $clog2(NUM_REGS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              issue_valid,
   output logic                              issue_ready,
   input  logic [ADDR_W-1:0]                 issue_reg,
   input  logic [WRITEBACK_PORTS-1:0]        writeback_valid,
   input  logic [WRITEBACK_PORTS*ADDR_W-1:0] writeback_reg,
   input  logic                              clear,
   input  logic [ADDR_W-1:0]                 rd_addr,
   input  logic [ADDR_W-1:0]                 rs1_addr,
   input  logic [ADDR_W-1:0]                 rs2_addr,
   input  logic [ADDR_W-1:0]                 rs3_addr,
   output logic                              rd_status,
   output logic                              rs1_status,
   output logic                              rs2_status,
   output logic                              rs3_status,
   output logic                              busy_any,
   output logic                              underflow_error
);

   localparam int DEC_W = $clog2(WRITEBACK_PORTS + 1);

   logic [NUM_REGS-1:0]      zero;
   logic [NUM_REGS-1:0]      full;
   logic [NUM_REGS-1:0]      underflow;
   logic [NUM_REGS-1:0]      inc;
   logic [DEC_W-1:0]         dec    [NUM_REGS];
   logic [COUNTER_WIDTH-1:0] counts [NUM_REGS];
   logic                     accept;
   logic                     underflow_q;

   // Handshake: a reservation is taken on issue_valid && issue_ready; ready looks only at
   // the registered count of issue_reg, never at issue_valid or same-cycle releases.
   assign issue_ready = !full[issue_reg];
   assign accept      = issue_valid && issue_ready;

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         dec[r] = '0;
         for (int p = 0; p < WRITEBACK_PORTS; p++) begin
            if (writeback_valid[p] && (writeback_reg[p*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
               dec[r] = dec[r] + DEC_W'(1);
            end
         end
      end
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign inc[r] = accept && (issue_reg == ADDR_W'(r));

      basilisk_scoreboard_counter #(
         .WIDTH (COUNTER_WIDTH),
         .DEC_W (DEC_W)
      ) u_counter (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc[r]),
         .dec       (dec[r]),
         .clear     (clear),
         .count     (counts[r]),
         .zero      (zero[r]),
         .full      (full[r]),
         .underflow (underflow[r])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         underflow_q <= 1'b0;
      end else if (|underflow) begin
         underflow_q <= 1'b1;
      end
   end

   always_comb begin
      busy_any = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_any = busy_any | (counts[r] != '0);
      end
   end

   assign underflow_error = underflow_q;
   assign rd_status       = zero[rd_addr];
   assign rs1_status      = zero[rs1_addr];
   assign rs2_status      = zero[rs2_addr];
   assign rs3_status      = zero[rs3_addr];

endmodule

// File: doc/basilisk_register_scoreboard.md
Name: basilisk_register_scoreboard

Overview:
- Maintains per-register pending-write state for the 32 floating-point/vector registers.
- Provides the 1-bit rd/rs1/rs2/rs3 status bits that the decode stage's dependency check consumes (1 = no pending write, 0 = hazard).
- Decode reserves a register at issue; execute-unit writebacks release it.
- Sits beside basilisk decode, fed by the writeback ports of the add/mult/divide/sqrt/memory units.

Parameters:
- NUM_REGS, 32, number of tracked registers; the address width is $clog2(NUM_REGS).
- COUNTER_WIDTH, 2, width of the per-register outstanding-write counter; saturation value MAX = 2^COUNTER_WIDTH-1.
- WRITEBACK_PORTS, 2, number of independent writeback release ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  decode requests a reservation
- issue_ready  out  1  reservation can be accepted this cycle
- issue_reg  in  5  register being reserved
- writeback_valid  in  WRITEBACK_PORTS  per-port release strobe
- writeback_reg  in  WRITEBACK_PORTS*5  per-port released register, packed; port i occupies bits [5i+4:5i]
- clear  in  1  synchronous flush of all reservations
- rd_addr, rs1_addr, rs2_addr, rs3_addr  in  5 each  query addresses
- rd_status, rs1_status, rs2_status, rs3_status  out  1 each  1 when the queried counter is 0
- busy_any  out  1  1 when any counter is nonzero
- underflow_error  out  1  sticky; a release was seen against a zero counter

Behaviour:
- State:
  - count[NUM_REGS][COUNTER_WIDTH]
  - underflow_error register
- Reset (rst=1 at a clk edge):
  - all counts become 0 and underflow_error becomes 0.
  - Resulting outputs: issue_ready=1, every *_status=1, busy_any=0.
  - Reset mid-operation discards all in-flight reservations. Writebacks in the reset cycle are ignored.
- Status outputs:
  - Combinational from the registered counts only; no bypass from same-cycle writeback or issue.
  - A release at edge N makes status=1 visible in cycle N+1.
  - A reservation accepted at edge N makes status=0 visible in cycle N+1.
  - Decode therefore sees its own reservation one cycle later and must hold its own hazard locally for back-to-back issue.
- Handshake:
  - A reservation is accepted when issue_valid && issue_ready.
  - issue_ready = (count[issue_reg] != MAX), computed from the registered value only. It does not depend on issue_valid or on same-cycle writebacks.
  - issue_reg must stay stable while issue_valid=1 and issue_ready=0.
- Update at each edge, per register r:
  - inc = accepted reservation && issue_reg==r (0 or 1).
  - dec = number of ports i with writeback_valid[i] && writeback_reg[i]==r (0..WRITEBACK_PORTS).
  - next = count + inc - dec, computed at COUNTER_WIDTH+2 bits signed.
  - If next < 0: count becomes 0 and underflow_error is set. It stays set until rst.
  - next can never exceed MAX, because inc is gated by issue_ready.
- Simultaneous events:
  - Issue and release of the same register with count=1: the count stays 1.
  - Issue and release of the same register with count=MAX: issue_ready=0, so there is no inc; the count becomes MAX-1.
  - Two ports releasing the same register with count=2: the count becomes 0.
- clear:
  - The next count is 0 for every register, overriding issue and writeback in that cycle. Any issue presented in a clear cycle is dropped, and issue_ready is not altered.
  - underflow_error is unaffected by clear.
- busy_any = OR over (count[r] != 0), registered view.
- Latency:
  - Status reflects issue or writeback one cycle after the edge.
  - The design has no internal pipeline.

Decomposition:
- Additions to package basilisk:
  - basilisk_reg_addr_t (logic [4:0])
  - BASILISK_SCOREBOARD_COUNTER_WIDTH
  - typedef basilisk_scoreboard_count_t
- Sub-module basilisk_scoreboard_counter: one per register, generated NUM_REGS times.
  - Inputs: inc, dec (multi-bit), clear.
  - Outputs: count, zero, full, underflow.
  - The top level ORs the underflow outputs into the sticky error and muxes zero/full by address.

Test Plan:
1. Reset, then query all 32 registers: every *_status=1, busy_any=0, issue_ready=1, underflow_error=0.
2. Issue reg 5 at cycle 1; query rs1_addr=5: rs1_status=0 from cycle 2. Writeback port0 reg 5 at cycle 4: rs1_status=1 from cycle 5, busy_any=0.
3. Issue reg 7 three times back-to-back: count=3 and issue_ready=0 with issue_reg=7. Stall holds for 2 cycles. Port1 writeback of reg 7: issue_ready=1 next cycle and the pending issue is accepted.
4. Count[9]=2; both ports write back reg 9 in the same cycle: count=0 and rd_status=1 next cycle, no error. Repeating the release gives underflow_error=1 and count stays 0.
5. Count[3]=1; issue reg 3 and writeback reg 3 in the same cycle: count remains 1 and status stays 0.
6. Reserve regs 1, 2 and 31, then assert clear together with issue reg 4: all status=1 next cycle, busy_any=0, reg 4 not reserved. Asserting rst mid-stream instead also zeroes everything.
